// File: rtl/snax_gemm_tile_sequencer_if.sv
// Tile-sequencer handshake bundle: TCDM read port,
// GEMM core strobes and C write-back port.
interface snax_gemm_tile_sequencer_if #(
  parameter int unsigned AddrWidth = 17
) ();
  logic                 rd_valid_o;
  logic                 rd_ready_i;
  logic [AddrWidth-1:0] rd_addr_a_o;
  logic [AddrWidth-1:0] rd_addr_b_o;
  logic                 rsp_valid_i;
  logic                 core_in_valid_o;
  logic                 core_acc_clr_o;
  logic                 core_out_valid_i;
  logic                 wr_valid_o;
  logic                 wr_ready_i;
  logic [AddrWidth-1:0] wr_addr_o;
  logic                 wr_half_o;

  modport master (
    output rd_valid_o, rd_addr_a_o, rd_addr_b_o,
    output core_in_valid_o, core_acc_clr_o,
    output wr_valid_o, wr_addr_o, wr_half_o,
    input  rd_ready_i, rsp_valid_i,
    input  core_out_valid_i, wr_ready_i
  );

  modport slave (
    input  rd_valid_o, rd_addr_a_o, rd_addr_b_o,
    input  core_in_valid_o, core_acc_clr_o,
    input  wr_valid_o, wr_addr_o, wr_half_o,
    output rd_ready_i, rsp_valid_i,
    output core_out_valid_i, wr_ready_i
  );
endinterface

// File: rtl/snax_gemm_tile_sequencer.sv
// Walks M/N/K tiles of a GEMM: fetches A/B tiles, strobes
// the core, and writes each C tile back in two halves.
module snax_gemm_tile_sequencer #(
  parameter int unsigned AddrWidth = 17,
  parameter int unsigned SizeWidth = 8
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 start_i,
  input  logic [AddrWidth-1:0] base_a_i,
  input  logic [AddrWidth-1:0] base_b_i,
  input  logic [AddrWidth-1:0] base_c_i,
  input  logic [AddrWidth-1:0] stride_a_i,
  input  logic [AddrWidth-1:0] stride_b_i,
  input  logic [AddrWidth-1:0] stride_c_i,
  input  logic [SizeWidth-1:0] m_i,
  input  logic [SizeWidth-1:0] n_i,
  input  logic [SizeWidth-1:0] k_i,
  snax_gemm_tile_sequencer_if.master bus,
  output logic                 busy_o,
  output logic                 done_o,
  output logic [31:0]          perf_cycles_o
);

  typedef enum logic [2:0] {
    IDLE, READ, WAIT_RSP, WAIT_OUT,
    WRITE1, WRITE2, FINISH
  } state_e;

  state_e               state_q;
  logic [AddrWidth-1:0] ba_q, bb_q, bc_q;
  logic [AddrWidth-1:0] sa_q, sb_q, sc_q;
  logic [SizeWidth-1:0] m_q, n_q, k_q;
  logic [SizeWidth-1:0] mi_q, ni_q, ki_q;
  logic [31:0]          perf_q;

  logic [AddrWidth-1:0] idx_a, idx_b, idx_c;
  logic [AddrWidth-1:0] addr_a, addr_b, addr_c;
  logic                 last_k, last_n, last_m;

  always_comb begin
    idx_a = AddrWidth'(mi_q) * AddrWidth'(k_q)
          + AddrWidth'(ki_q);
    idx_b = AddrWidth'(ni_q) * AddrWidth'(k_q)
          + AddrWidth'(ki_q);
    idx_c = AddrWidth'(mi_q) * AddrWidth'(n_q)
          + AddrWidth'(ni_q);
    addr_a = ba_q + idx_a * sa_q;
    addr_b = bb_q + idx_b * sb_q;
    addr_c = bc_q + idx_c * sc_q;
  end

  assign last_k = (ki_q == k_q - SizeWidth'(1));
  assign last_n = (ni_q == n_q - SizeWidth'(1));
  assign last_m = (mi_q == m_q - SizeWidth'(1));

  // Everything not owned by the current state stays at zero.
  always_comb begin
    bus.rd_valid_o      = 1'b0;
    bus.rd_addr_a_o     = '0;
    bus.rd_addr_b_o     = '0;
    bus.core_in_valid_o = 1'b0;
    bus.core_acc_clr_o  = 1'b0;
    bus.wr_valid_o      = 1'b0;
    bus.wr_addr_o       = '0;
    bus.wr_half_o       = 1'b0;
    unique case (1'b1)
      (state_q == READ): begin
        bus.rd_valid_o  = 1'b1;
        bus.rd_addr_a_o = addr_a;
        bus.rd_addr_b_o = addr_b;
      end
      (state_q == WAIT_RSP): begin
        bus.core_in_valid_o = bus.rsp_valid_i;
        bus.core_acc_clr_o  = bus.rsp_valid_i
                            & (ki_q == '0);
      end
      (state_q == WRITE1): begin
        bus.wr_valid_o = 1'b1;
        bus.wr_addr_o  = addr_c;
      end
      (state_q == WRITE2): begin
        bus.wr_valid_o = 1'b1;
        bus.wr_addr_o  = addr_c + AddrWidth'(128);
        bus.wr_half_o  = 1'b1;
      end
      default: ;
    endcase
  end

  assign busy_o        = (state_q != IDLE);
  assign done_o        = (state_q == FINISH);
  assign perf_cycles_o = perf_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      ba_q <= '0; bb_q <= '0; bc_q <= '0;
      sa_q <= '0; sb_q <= '0; sc_q <= '0;
      m_q  <= '0; n_q  <= '0; k_q  <= '0;
      mi_q <= '0; ni_q <= '0; ki_q <= '0;
      perf_q <= '0;
    end else begin
      if (busy_o && perf_q != '1) perf_q <= perf_q + 32'd1;
      unique case (state_q)
        IDLE: if (start_i) begin
          ba_q <= base_a_i;   bb_q <= base_b_i;
          bc_q <= base_c_i;   sa_q <= stride_a_i;
          sb_q <= stride_b_i; sc_q <= stride_c_i;
          m_q  <= m_i; n_q <= n_i; k_q <= k_i;
          mi_q <= '0; ni_q <= '0; ki_q <= '0;
          perf_q <= '0;
          if (m_i == '0 || n_i == '0 || k_i == '0)
            state_q <= FINISH;
          else
            state_q <= READ;
        end
        READ: if (bus.rd_ready_i) state_q <= WAIT_RSP;
        WAIT_RSP: if (bus.rsp_valid_i) begin
          if (last_k) begin
            state_q <= WAIT_OUT;
          end else begin
            ki_q    <= ki_q + SizeWidth'(1);
            state_q <= READ;
          end
        end
        WAIT_OUT: if (bus.core_out_valid_i) state_q <= WRITE1;
        WRITE1: if (bus.wr_ready_i) state_q <= WRITE2;
        WRITE2: if (bus.wr_ready_i) begin
          ki_q <= '0;
          if (last_n) begin
            ni_q <= '0;
            mi_q <= mi_q + SizeWidth'(1);
            state_q <= last_m ? FINISH : READ;
          end else begin
            ni_q    <= ni_q + SizeWidth'(1);
            state_q <= READ;
          end
        end
        FINISH: state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_snax_gemm_tile_sequencer.sv
// Directed bench for the GEMM tile sequencer: vector
// table plus stall, restart-ignore and reset sequences.
module tb_snax_gemm_tile_sequencer;
  localparam int AW = 17;
  localparam int SW = 8;

  logic          clk = 1'b0;
  logic          rst, start;
  logic [AW-1:0] ba, bb, bc, sa, sb, sc;
  logic [SW-1:0] m, n, k;
  logic          busy, done;
  logic [31:0]   perf;

  snax_gemm_tile_sequencer_if #(.AddrWidth(AW)) bus ();

  snax_gemm_tile_sequencer #(
    .AddrWidth(AW), .SizeWidth(SW)
  ) dut (
    .clk_i(clk), .rst_i(rst), .start_i(start),
    .base_a_i(ba), .base_b_i(bb), .base_c_i(bc),
    .stride_a_i(sa), .stride_b_i(sb), .stride_c_i(sc),
    .m_i(m), .n_i(n), .k_i(k),
    .bus(bus),
    .busy_o(busy), .done_o(done),
    .perf_cycles_o(perf)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [SW-1:0]         m, n, k;
    logic [AW-1:0]         ba, bb, bc, sa, sb, sc;
    int                    nrd;
    logic [3:0][AW-1:0]    ea, eb;
    logic [3:0]            eclr;
    int                    nwr;
    logic [3:0][AW-1:0]    ew;
    int                    perf;
  } vec_t;

  vec_t vecs[6];

  int n_vec = 0;
  int n_bad = 0;

  logic [AW-1:0] qa[$], qb[$], qw[$];
  logic          qclr[$], qh[$];
  int            done_cnt;

  function automatic logic [3:0][AW-1:0] l4(
    input logic [AW-1:0] a0, a1, a2, a3);
    logic [3:0][AW-1:0] r;
    r[0] = a0; r[1] = a1; r[2] = a2; r[3] = a3;
    return r;
  endfunction

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (bus.rd_valid_o && bus.rd_ready_i) begin
        qa.push_back(bus.rd_addr_a_o);
        qb.push_back(bus.rd_addr_b_o);
      end
      if (bus.core_in_valid_o)
        qclr.push_back(bus.core_acc_clr_o);
      if (bus.wr_valid_o && bus.wr_ready_i) begin
        qw.push_back(bus.wr_addr_o);
        qh.push_back(bus.wr_half_o);
      end
      if (done) done_cnt++;
    end
  end

  task automatic launch(input vec_t v);
    qa.delete(); qb.delete(); qw.delete();
    qclr.delete(); qh.delete();
    done_cnt = 0;
    m = v.m; n = v.n; k = v.k;
    ba = v.ba; bb = v.bb; bc = v.bc;
    sa = v.sa; sb = v.sb; sc = v.sc;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic collect_check(input vec_t v,
                               input string nm);
    int t = 0;
    while (done_cnt == 0 && t < 500) begin
      @(posedge clk);
      t++;
    end
    chk({nm, "_done_seen"}, 32'(done_cnt > 0), 1);
    @(negedge clk);
    chk({nm, "_perf"}, perf, v.perf);
    chk({nm, "_ndone"}, done_cnt, 1);
    chk({nm, "_nrd"}, qa.size(), v.nrd);
    chk({nm, "_nclr"}, qclr.size(), v.nrd);
    chk({nm, "_nwr"}, qw.size(), v.nwr);
    for (int i = 0; i < v.nrd; i++) begin
      if (i < qa.size()) begin
        chk($sformatf("%s_a%0d", nm, i), 32'(qa[i]),
            32'(v.ea[i]));
        chk($sformatf("%s_b%0d", nm, i), 32'(qb[i]),
            32'(v.eb[i]));
      end
      if (i < qclr.size())
        chk($sformatf("%s_clr%0d", nm, i),
            32'(qclr[i]), 32'(v.eclr[i]));
    end
    for (int i = 0; i < v.nwr; i++) begin
      if (i < qw.size()) begin
        chk($sformatf("%s_w%0d", nm, i), 32'(qw[i]),
            32'(v.ew[i]));
        chk($sformatf("%s_h%0d", nm, i), 32'(qh[i]),
            32'(i % 2));
      end
    end
  endtask

  initial begin
    vec_t v;
    int   t;
    vecs[0] = '{8'd1, 8'd1, 8'd1,
      17'h100, 17'h200, 17'h300, 17'h40, 17'h40, 17'h40,
      1, l4(17'h100, 0, 0, 0), l4(17'h200, 0, 0, 0),
      4'b0001, 2, l4(17'h300, 17'h380, 0, 0), 6};
    vecs[1] = '{8'd1, 8'd2, 8'd2,
      17'h100, 17'h200, 17'h300, 17'h40, 17'h40, 17'h100,
      4, l4(17'h100, 17'h140, 17'h100, 17'h140),
      l4(17'h200, 17'h240, 17'h280, 17'h2C0),
      4'b0101, 4,
      l4(17'h300, 17'h380, 17'h400, 17'h480), 15};
    vecs[2] = '{8'd2, 8'd1, 8'd1,
      17'h100, 17'h200, 17'h300, 17'h40, 17'h40, 17'h100,
      2, l4(17'h100, 17'h140, 0, 0),
      l4(17'h200, 17'h200, 0, 0), 4'b0011, 4,
      l4(17'h300, 17'h380, 17'h400, 17'h480), 11};
    vecs[3] = '{8'd2, 8'd1, 8'd1,
      17'h1FFC0, 17'h200, 17'h1FFC0, 17'h40, 17'h10, 17'h40,
      2, l4(17'h1FFC0, 17'h00000, 0, 0),
      l4(17'h200, 17'h200, 0, 0), 4'b0011, 4,
      l4(17'h1FFC0, 17'h00040, 17'h00000, 17'h00080), 11};
    vecs[4] = '{8'd1, 8'd1, 8'd0,
      17'h100, 17'h200, 17'h300, 17'h40, 17'h40, 17'h40,
      0, l4(0, 0, 0, 0), l4(0, 0, 0, 0), 4'b0000, 0,
      l4(0, 0, 0, 0), 1};
    vecs[5] = '{8'd0, 8'd3, 8'd2,
      17'h100, 17'h200, 17'h300, 17'h40, 17'h40, 17'h40,
      0, l4(0, 0, 0, 0), l4(0, 0, 0, 0), 4'b0000, 0,
      l4(0, 0, 0, 0), 1};

    rst = 1'b1; start = 1'b0; done_cnt = 0;
    m = '0; n = '0; k = '0;
    ba = '0; bb = '0; bc = '0;
    sa = '0; sb = '0; sc = '0;
    bus.rd_ready_i = 1'b1;
    bus.rsp_valid_i = 1'b1;
    bus.core_out_valid_i = 1'b1;
    bus.wr_ready_i = 1'b1;

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_perf", perf, 0);
    chk("rst_rd_valid", bus.rd_valid_o, 0);
    chk("rst_rd_addr_a", 32'(bus.rd_addr_a_o), 0);
    chk("rst_rd_addr_b", 32'(bus.rd_addr_b_o), 0);
    chk("rst_wr_valid", bus.wr_valid_o, 0);
    chk("rst_wr_addr", 32'(bus.wr_addr_o), 0);
    chk("rst_wr_half", bus.wr_half_o, 0);
    chk("idle_core_in", bus.core_in_valid_o, 0);
    chk("idle_acc_clr", bus.core_acc_clr_o, 0);
    rst = 1'b0;

    for (int i = 0; i < 6; i++) begin
      launch(vecs[i]);
      collect_check(vecs[i], $sformatf("vec%0d", i));
    end

    // k=0: FINISH is the cycle after the start cycle
    @(negedge clk);
    m = 8'd1; n = 8'd1; k = 8'd0;
    done_cnt = 0;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    @(negedge clk);
    chk("k0_done_c2", done, 1);
    chk("k0_busy_c2", busy, 1);
    @(negedge clk);
    chk("k0_done_c3", done, 0);
    chk("k0_busy_c3", busy, 0);
    chk("k0_perf", perf, 1);

    // read stalled 5 cycles, write stalled 3 cycles
    bus.rd_ready_i = 1'b0;
    bus.wr_ready_i = 1'b0;
    launch(vecs[0]);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk($sformatf("stall_rv%0d", i), bus.rd_valid_o, 1);
      chk($sformatf("stall_ra%0d", i),
          32'(bus.rd_addr_a_o), 32'h100);
      chk($sformatf("stall_rb%0d", i),
          32'(bus.rd_addr_b_o), 32'h200);
      @(posedge clk);
    end
    #1 bus.rd_ready_i = 1'b1;
    t = 0;
    @(negedge clk);
    while (!bus.wr_valid_o && t < 50) begin
      @(negedge clk);
      t++;
    end
    chk("stall_wr_seen", bus.wr_valid_o, 1);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("stall_wa%0d", i),
          32'(bus.wr_addr_o), 32'h300);
      chk($sformatf("stall_wh%0d", i), bus.wr_half_o, 0);
      @(posedge clk);
      @(negedge clk);
    end
    bus.wr_ready_i = 1'b1;
    v = vecs[0];
    v.perf = 6 + 5 + 3;
    collect_check(v, "stall");

    // second start with other config while busy
    @(negedge clk);
    launch(vecs[1]);
    repeat (4) @(posedge clk);
    #1;
    m = 8'd3; n = 8'd3; k = 8'd3;
    ba = 17'h5000; bb = 17'h6000; bc = 17'h7000;
    sa = 17'h8; sb = 17'h8; sc = 17'h8;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    collect_check(vecs[1], "ignstart");

    // reset while waiting on the core
    @(negedge clk);
    bus.core_out_valid_i = 1'b0;
    launch(vecs[0]);
    t = 0;
    @(negedge clk);
    while (!bus.core_in_valid_o && t < 50) begin
      @(negedge clk);
      t++;
    end
    chk("rstmid_core_in_seen", bus.core_in_valid_o, 1);
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    bus.core_out_valid_i = 1'b1;
    @(negedge clk);
    chk("rstmid_busy", busy, 0);
    chk("rstmid_done", done, 0);
    chk("rstmid_perf", perf, 0);
    chk("rstmid_wr_valid", bus.wr_valid_o, 0);
    chk("rstmid_rd_valid", bus.rd_valid_o, 0);
    chk("rstmid_ndone", done_cnt, 0);
    launch(vecs[0]);
    collect_check(vecs[0], "postrst");

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

endmodule
